// File: rtl/wb_stage.sv
// Writeback stage: small result FIFO feeding registered dstE/valE/dstM/valM to the register file.
// Optional WB_RETIRE_CNT_EN adds a 32-bit count of retired AOK instructions on retire_cnt.
module wb_stage #(
    parameter int DEPTH = 2,
    parameter int NREG  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_dstE,
    input  logic [31:0] in_valE,
    input  logic [3:0]  in_dstM,
    input  logic [31:0] in_valM,
    input  logic [2:0]  in_stat,
    input  logic        wb_stall,
    output logic [3:0]  dstE,
    output logic [31:0] valE,
    output logic [3:0]  dstM,
    output logic [31:0] valM,
    output logic        halted,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0] retire_cnt,
`endif
    output logic [2:0]  stat
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [3:0] NO_REG   = 4'hF;

    typedef struct packed {
        logic [3:0]  dstE;
        logic [31:0] valE;
        logic [3:0]  dstM;
        logic [31:0] valM;
        logic [2:0]  stat;
    } entry_t;

    entry_t          fifoMem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            halted_q, halted_d;
    logic [3:0]      dstE_q, dstE_d, dstM_q, dstM_d;
    logic [31:0]     valE_q, valE_d, valM_q, valM_d;
    logic [2:0]      stat_q, stat_d;
    logic            push, pop, headFault, headEOk, headMOk;

    function automatic logic regInRange(input logic [3:0] idx);
        return 32'(idx) < 32'(NREG);
    endfunction

    always_comb begin
        head      = fifoMem[rdPtr_q];
        in_ready  = (count_q < CW'(DEPTH)) && !halted_q;
        push      = in_valid && in_ready;
        pop       = (count_q != '0) && !wb_stall && !halted_q;
        headFault = (head.stat == STAT_ADR) || (head.stat == STAT_INS);
        headMOk   = regInRange(head.dstM) && !headFault;
        headEOk   = regInRange(head.dstE) && !headFault && !(headMOk && head.dstE == head.dstM);

        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        halted_d = halted_q;
        dstE_d   = NO_REG;
        dstM_d   = NO_REG;
        valE_d   = valE_q;
        valM_d   = valM_q;
        stat_d   = stat_q;

        if (push) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
            dstE_d  = headEOk ? head.dstE : NO_REG;
            dstM_d  = headMOk ? head.dstM : NO_REG;
            valE_d  = head.valE;
            valM_d  = head.valM;
            stat_d  = head.stat;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A non-AOK retirement stops the machine and discards anything queued behind it.
        if (pop && head.stat != STAT_AOK) begin
            halted_d = 1'b1;
            count_d  = '0;
            rdPtr_d  = wrPtr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wrPtr_q] <= '{dstE: in_dstE, valE: in_valE, dstM: in_dstM,
                                  valM: in_valM, stat: in_stat};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
            dstE_q   <= NO_REG;
            dstM_q   <= NO_REG;
            valE_q   <= '0;
            valM_q   <= '0;
            stat_q   <= STAT_AOK;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
            dstE_q   <= dstE_d;
            dstM_q   <= dstM_d;
            valE_q   <= valE_d;
            valM_q   <= valM_d;
            stat_q   <= stat_d;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retireCnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retireCnt_q <= '0;
        end else if (pop && head.stat == STAT_AOK) begin
            retireCnt_q <= retireCnt_q + 32'd1;
        end
    end

    assign retire_cnt = retireCnt_q;
`endif

    assign dstE   = dstE_q;
    assign dstM   = dstM_q;
    assign valE   = valE_q;
    assign valM   = valM_q;
    assign halted = halted_q;
    assign stat   = stat_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a per-cycle vector table plus hand-written fault, halt and reset sequences.
// Also checks retire_cnt when built with WB_RETIRE_CNT_EN.
module tb_wb_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [3:0]  inDstE = 4'hF;
    logic [31:0] inValE = '0;
    logic [3:0]  inDstM = 4'hF;
    logic [31:0] inValM = '0;
    logic [2:0]  inStat = 3'd1;
    logic        wbStall = 1'b0;
    logic [3:0]  dstE, dstM;
    logic [31:0] valE, valM;
    logic        halted;
    logic [2:0]  stat;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retireCnt;
`endif

    int checkCount = 0;
    int passCount  = 0;

    always #5 clock = ~clock;

    wb_stage #(.DEPTH(2), .NREG(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_dstE    (inDstE),
        .in_valE    (inValE),
        .in_dstM    (inDstM),
        .in_valM    (inValM),
        .in_stat    (inStat),
        .wb_stall   (wbStall),
        .dstE       (dstE),
        .valE       (valE),
        .dstM       (dstM),
        .valM       (valM),
        .halted     (halted),
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt (retireCnt),
`endif
        .stat       (stat)
    );

    typedef struct {
        logic        valid;
        logic        stall;
        logic [3:0]  dE;
        logic [31:0] vE;
        logic [3:0]  dM;
        logic [31:0] vM;
        logic [2:0]  st;
        logic        expReady;
        logic [3:0]  expDstE;
        logic        chkValE;
        logic [31:0] expValE;
        logic [3:0]  expDstM;
        logic        chkValM;
        logic [31:0] expValM;
        logic [2:0]  expStat;
        logic        expHalted;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [3:0] dE, input logic [31:0] vE,
                                 input logic [3:0] dM, input logic [31:0] vM, input logic [2:0] st);
        inValid = v;
        wbStall = s;
        inDstE  = dE;
        inValE  = vE;
        inDstM  = dM;
        inValM  = vM;
        inStat  = st;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 4'hF, '0, 4'hF, '0, 3'd1);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        // in: valid stall dE vE dM vM st | exp: ready dstE chkE valE dstM chkM valM stat halted
        vecs[0]  = '{1, 0, 4'd2, 32'hABCDEF98, 4'hF, 32'h0,        3'd1, 1, 4'hF, 1, 32'h0,        4'hF, 1, 32'h0,        3'd1, 0};
        vecs[1]  = '{1, 0, 4'd3, 32'h11111111, 4'd3, 32'h22222222, 3'd1, 1, 4'd2, 1, 32'hABCDEF98, 4'hF, 0, 32'h0,        3'd1, 0};
        vecs[2]  = '{1, 0, 4'd9, 32'h33333333, 4'd4, 32'h44444444, 3'd1, 1, 4'hF, 0, 32'h0,        4'd3, 1, 32'h22222222, 3'd1, 0};
        vecs[3]  = '{0, 0, 4'hF, 32'h0,        4'hF, 32'h0,        3'd1, 1, 4'hF, 0, 32'h0,        4'd4, 1, 32'h44444444, 3'd1, 0};
        vecs[4]  = '{1, 0, 4'd7, 32'h00000055, 4'd8, 32'h00000066, 3'd1, 1, 4'hF, 0, 32'h0,        4'hF, 1, 32'h44444444, 3'd1, 0};
        vecs[5]  = '{0, 0, 4'hF, 32'h0,        4'hF, 32'h0,        3'd1, 1, 4'd7, 1, 32'h00000055, 4'hF, 0, 32'h0,        3'd1, 0};
        vecs[6]  = '{0, 0, 4'hF, 32'h0,        4'hF, 32'h0,        3'd1, 1, 4'hF, 1, 32'h00000055, 4'hF, 0, 32'h0,        3'd1, 0};
        vecs[7]  = '{1, 1, 4'd1, 32'h000000A1, 4'hF, 32'h0,        3'd1, 1, 4'hF, 1, 32'h00000055, 4'hF, 0, 32'h0,        3'd1, 0};
        vecs[8]  = '{1, 1, 4'd2, 32'h000000B2, 4'd6, 32'h000000B6, 3'd1, 0, 4'hF, 1, 32'h00000055, 4'hF, 0, 32'h0,        3'd1, 0};
        vecs[9]  = '{1, 1, 4'd3, 32'h000000C3, 4'hF, 32'h0,        3'd1, 0, 4'hF, 1, 32'h00000055, 4'hF, 0, 32'h0,        3'd1, 0};
        vecs[10] = '{1, 0, 4'd3, 32'h000000C3, 4'hF, 32'h0,        3'd1, 1, 4'd1, 1, 32'h000000A1, 4'hF, 0, 32'h0,        3'd1, 0};
        vecs[11] = '{1, 0, 4'd3, 32'h000000C3, 4'hF, 32'h0,        3'd1, 1, 4'd2, 1, 32'h000000B2, 4'd6, 1, 32'h000000B6, 3'd1, 0};
        vecs[12] = '{0, 0, 4'hF, 32'h0,        4'hF, 32'h0,        3'd1, 1, 4'd3, 1, 32'h000000C3, 4'hF, 0, 32'h0,        3'd1, 0};
        vecs[13] = '{0, 0, 4'hF, 32'h0,        4'hF, 32'h0,        3'd1, 1, 4'hF, 1, 32'h000000C3, 4'hF, 0, 32'h0,        3'd1, 0};

        doReset();
        #1;
        checkOutput("reset.dstE",    32'(dstE),    32'hF);
        checkOutput("reset.dstM",    32'(dstM),    32'hF);
        checkOutput("reset.valE",    valE,         32'h0);
        checkOutput("reset.valM",    valM,         32'h0);
        checkOutput("reset.stat",    32'(stat),    32'd1);
        checkOutput("reset.halted",  32'(halted),  32'd0);
        checkOutput("reset.inReady", 32'(inReady), 32'd1);

        // Table: inputs are applied for one edge, outputs sampled 1 time unit after it.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].stall, vecs[i].dE, vecs[i].vE, vecs[i].dM, vecs[i].vM, vecs[i].st);
            stepCycle();
            checkOutput($sformatf("vec%0d.inReady", i), 32'(inReady), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d.dstE", i),    32'(dstE),    32'(vecs[i].expDstE));
            checkOutput($sformatf("vec%0d.dstM", i),    32'(dstM),    32'(vecs[i].expDstM));
            checkOutput($sformatf("vec%0d.stat", i),    32'(stat),    32'(vecs[i].expStat));
            checkOutput($sformatf("vec%0d.halted", i),  32'(halted),  32'(vecs[i].expHalted));
            if (vecs[i].chkValE) checkOutput($sformatf("vec%0d.valE", i), valE, vecs[i].expValE);
            if (vecs[i].chkValM) checkOutput($sformatf("vec%0d.valM", i), valM, vecs[i].expValM);
        end
`ifdef WB_RETIRE_CNT_EN
        checkOutput("table.retireCnt", retireCnt, 32'd7);
`endif

        // ADR fault: nothing committed, sticky halt, later pushes refused.
        doReset();
        applyStimulus(1'b1, 1'b0, 4'd1, 32'h77, 4'd4, 32'h88, 3'd3);
        stepCycle();
        checkOutput("adr.pushReady", 32'(inReady), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'd5, 32'h99, 4'hF, 32'h0, 3'd1);
        stepCycle();
        checkOutput("adr.dstE",    32'(dstE),    32'hF);
        checkOutput("adr.dstM",    32'(dstM),    32'hF);
        checkOutput("adr.stat",    32'(stat),    32'd3);
        checkOutput("adr.halted",  32'(halted),  32'd1);
        checkOutput("adr.inReady", 32'(inReady), 32'd0);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput($sformatf("adr.after%0d.dstE", i),    32'(dstE),    32'hF);
            checkOutput($sformatf("adr.after%0d.inReady", i), 32'(inReady), 32'd0);
            checkOutput($sformatf("adr.after%0d.halted", i),  32'(halted),  32'd1);
            checkOutput($sformatf("adr.after%0d.stat", i),    32'(stat),    32'd3);
        end
`ifdef WB_RETIRE_CNT_EN
        checkOutput("adr.retireCnt", retireCnt, 32'd0);
`endif

        // HLT with an AOK entry queued behind it: the queued r5 write must never appear.
        doReset();
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h0, 4'hF, 32'h0, 3'd2);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 4'd5, 32'h55555555, 4'hF, 32'h0, 3'd1);
        stepCycle();
        checkOutput("hlt.stat",    32'(stat),    32'd2);
        checkOutput("hlt.halted",  32'(halted),  32'd1);
        checkOutput("hlt.inReady", 32'(inReady), 32'd0);
        checkOutput("hlt.dstE",    32'(dstE),    32'hF);
        applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 4'hF, 32'h0, 3'd1);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput($sformatf("hlt.after%0d.dstE", i), 32'(dstE), 32'hF);
            checkOutput($sformatf("hlt.after%0d.stat", i), 32'(stat), 32'd2);
        end
`ifdef WB_RETIRE_CNT_EN
        checkOutput("hlt.retireCnt", retireCnt, 32'd0);
`endif

        // Asynchronous reset with two entries buffered behind a stall.
        doReset();
        applyStimulus(1'b1, 1'b0, 4'd2, 32'hDEAD0001, 4'hF, 32'h0, 3'd1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 4'hF, 32'h0, 3'd1);
        stepCycle();
        checkOutput("rst.pre.dstE", 32'(dstE), 32'd2);
        checkOutput("rst.pre.valE", valE,      32'hDEAD0001);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("rst.pre.retireCnt", retireCnt, 32'd1);
`endif
        applyStimulus(1'b1, 1'b1, 4'd1, 32'h1, 4'd2, 32'h2, 3'd1);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 4'd3, 32'h3, 4'd4, 32'h4, 3'd1);
        stepCycle();
        checkOutput("rst.full.inReady", 32'(inReady), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'hF, 32'h0, 4'hF, 32'h0, 3'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst.async.dstE",    32'(dstE),    32'hF);
        checkOutput("rst.async.dstM",    32'(dstM),    32'hF);
        checkOutput("rst.async.valE",    valE,         32'h0);
        checkOutput("rst.async.valM",    valM,         32'h0);
        checkOutput("rst.async.stat",    32'(stat),    32'd1);
        checkOutput("rst.async.halted",  32'(halted),  32'd0);
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 4'hF, 32'h0, 3'd1);
        #1;
        checkOutput("rst.rel.inReady", 32'(inReady), 32'd1);
        stepCycle();
        checkOutput("rst.empty.dstE", 32'(dstE), 32'hF);
        checkOutput("rst.empty.dstM", 32'(dstM), 32'hF);
        checkOutput("rst.empty.valE", valE,      32'h0);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("rst.retireCnt", retireCnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the 8-entry register file.
- Accepts retired-instruction results (E and M destinations and values, plus status) from the memory stage over a valid/ready handshake.
- Buffers them in a small FIFO, then drives registered dstE/valE/dstM/valM to the register file, one instruction per cycle.
- Enforces no-write encodings, E/M same-register conflict policy and sticky halt on non-AOK status.

Parameters:
- DEPTH, 2, FIFO entries (power of 2, at least 2).
- NREG, 8, number of architectural registers; any index >= NREG means "no write".

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept a result.
- in_dstE  input  4  E destination index.
- in_valE  input  32  E value.
- in_dstM  input  4  M destination index.
- in_valM  input  32  M value.
- in_stat  input  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- wb_stall  input  1  hold the FIFO head; no pop this cycle.
- dstE  output  4  register-file E write index; 4'hF means no write.
- valE  output  32  register-file E write value.
- dstM  output  4  register-file M write index; 4'hF means no write.
- valM  output  32  register-file M write value.
- halted  output  1  sticky; machine has stopped.
- stat  output  3  status of the last popped entry.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, pointers 0, dstE=dstM=4'hF, valE=valM=0, halted=0, stat=1. in_ready reads 1 once reset deasserts.
- in_ready = (count < DEPTH) && !halted, combinational from registered state.
- Push: occurs on an edge where in_valid && in_ready; stores all five fields at the write pointer.
- Pop: occurs on every edge where count > 0, !wb_stall and !halted.
- Pointers wrap modulo DEPTH.
- Push and pop on the same edge: count unchanged.
- When full, no push occurs even if a pop happens that cycle.
- Output register on a pop edge loads the head entry's fields, with these rules:
  - Any dst >= NREG is driven as 4'hF; its val is still driven but is don't-care.
  - If dstE == dstM < NREG, dstE is driven as 4'hF and M wins.
  - If stat is ADR or INS, both dsts are driven as 4'hF (faulting instruction is not committed).
  - stat output loads the head's stat.
- Output register on a non-pop edge (empty, stalled or halted): dstE=dstM=4'hF, val outputs hold, stat holds.
- Latency: with the FIFO empty and no stall, a push at edge N is popped at edge N+1 and written into the register file at edge N+2.
- Halt: on popping an entry with stat != AOK, set halted=1 on the same edge.
  - Flush the FIFO (count=0) on that edge.
  - in_ready drops to 0 and stays there; only reset clears halted.
- Stall: wb_stall=1 holds the FIFO contents and drives the outputs to no-write. Pushes continue until the FIFO is full.
- Reset mid-operation discards all buffered entries; no partial write is issued.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: adds output retire_cnt (32 bits).
  - Reset value 0.
  - Increments by 1 on each pop of an AOK entry; wraps from FFFFFFFF to 0.
  - HLT, ADR and INS pops do not count.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Single push (dstE=2, valE=32'hABCDEF98, dstM=4'hF, stat=1) into an empty FIFO -> at edge N+1, dstE=2, valE=ABCDEF98, dstM=F; the following cycle drives dstE=dstM=F.
- Conflict: push dstE=3, valE=11111111, dstM=3, valM=22222222 -> outputs dstE=F, dstM=3, valM=22222222.
- Out-of-range and fault handling:
  - Push dstE=9 (NREG=8) -> dstE=F.
  - Push dstE=1, dstM=4, stat=3 (ADR) -> dstE=dstM=F, stat=3, halted=1, in_ready=0; a later in_valid is ignored.
- Backpressure: wb_stall=1, push 3 back-to-back entries -> in_ready=0 after 2 accepted. Release the stall -> entries pop in order over 2 cycles, then the third is accepted.
- HLT with a queued entry behind it: push HLT then AOK(dstE=5) -> HLT pops, halted=1, FIFO flushed, and r5 is never written (dstE stays F).
- Assert reset=0 asynchronously mid-stream with 2 entries buffered -> outputs go immediately to reset values; after release, in_ready=1 and the FIFO is empty. With WB_RETIRE_CNT_EN, retire_cnt=0.
